// File: rtl/scan_pkg.sv
// Shared types and widths for the scan_seq channel scan sequencer.
package scan_pkg;

  localparam int unsigned NUM_CH  = 8;
  localparam int unsigned SEL_W   = 3;
  localparam int unsigned DWELL_W = 8;

  typedef enum logic {
    IDLE,
    RUN
  } state_t;

endpackage

// File: rtl/scan_seq_if.sv
// Request/select bundle between a scan requester and the scan_seq sequencer.
interface scan_seq_if;
  import scan_pkg::*;

  logic              start;
  logic              stop;
  logic [NUM_CH-1:0] mask;
  logic [SEL_W-1:0]  sel;
  logic              sel_vld;
  logic              busy;
  logic              done;

  modport master (
    output start, stop, mask,
    input  sel, sel_vld, busy, done
  );

  modport slave (
    input  start, stop, mask,
    output sel, sel_vld, busy, done
  );

endinterface

// File: rtl/scan_next.sv
// Finds the lowest set mask bit strictly above cur, or the lowest set bit overall when from_bottom is high.
module scan_next
  import scan_pkg::*;
(
  input  logic [NUM_CH-1:0] mask,
  input  logic [SEL_W-1:0]  cur,
  input  logic              from_bottom,
  output logic [SEL_W-1:0]  nxt,
  output logic              found
);

  always_comb begin
    nxt   = '0;
    found = 1'b0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      if (!found && mask[i] && (from_bottom || (i > 32'(cur)))) begin
        nxt   = SEL_W'(i);
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/scan_seq.sv
// Channel scan sequencer: steps a 3-bit decoder select through the enabled mask channels, DWELL cycles each.
// Optional SCAN_SEQ_LOOP_EN: wrap to the lowest channel at end of pass instead of returning to IDLE.
module scan_seq
  import scan_pkg::*;
#(
  parameter int unsigned DWELL = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  scan_seq_if.slave  bus
);

  if ((DWELL == 0) || (DWELL > 255)) begin : g_dwell_chk
    $error("scan_seq: DWELL must be in 1..255");
  end

  localparam logic [DWELL_W-1:0] RELOAD = DWELL_W'(DWELL - 1);

  state_t              state;
  logic [NUM_CH-1:0]   mask_q;
  logic [DWELL_W-1:0]  cnt;
  logic [SEL_W-1:0]    sel_q;
  logic                vld_q;
  logic                busy_q;
  logic                done_q;

  logic [NUM_CH-1:0]   first_mask;
  logic [SEL_W-1:0]    first_idx;
  logic                first_found;
  logic [SEL_W-1:0]    adv_idx;
  logic                adv_found;

  // The bottom-up search serves the start pick in IDLE and the wrap pick in RUN.
  assign first_mask = (state == IDLE) ? bus.mask : mask_q;

  scan_next u_first (
    .mask        (first_mask),
    .cur         ('0),
    .from_bottom (1'b1),
    .nxt         (first_idx),
    .found       (first_found)
  );

  scan_next u_adv (
    .mask        (mask_q),
    .cur         (sel_q),
    .from_bottom (1'b0),
    .nxt         (adv_idx),
    .found       (adv_found)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= IDLE;
      mask_q <= '0;
      cnt    <= '0;
      sel_q  <= '0;
      vld_q  <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start && !bus.stop) begin
            if (first_found) begin
              mask_q <= bus.mask;
              state  <= RUN;
              sel_q  <= first_idx;
              vld_q  <= 1'b1;
              busy_q <= 1'b1;
              cnt    <= RELOAD;
            end else begin
              done_q <= 1'b1;
            end
          end
        end
        RUN: begin
          if (bus.stop) begin
            state  <= IDLE;
            vld_q  <= 1'b0;
            busy_q <= 1'b0;
          end else if (cnt != '0) begin
            cnt <= cnt - 1'b1;
          end else if (adv_found) begin
            sel_q <= adv_idx;
            cnt   <= RELOAD;
          end else begin
`ifdef SCAN_SEQ_LOOP_EN
            sel_q  <= first_idx;
            cnt    <= RELOAD;
            done_q <= 1'b1;
`else
            state  <= IDLE;
            vld_q  <= 1'b0;
            busy_q <= 1'b0;
            done_q <= 1'b1;
`endif
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.sel     = sel_q;
  assign bus.sel_vld = vld_q;
  assign bus.busy    = busy_q;
  assign bus.done    = done_q;

endmodule

// File: tb/tb_scan_seq.sv
// Bench for scan_seq: three instances (DWELL 1, 2, 4) share stimulus and are checked every cycle against a pass-position model.
module tb_scan_seq;
  import scan_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic       stop;
  logic [7:0] mask;

  always #5 clk = ~clk;

  int checks = 0;
  int errs   = 0;
  int dwv[3] = '{1, 2, 4};

  logic [2:0] asel[3];
  logic       avld[3];
  logic       abusy[3];
  logic       adone[3];

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int unsigned DW = (g == 0) ? 1 : ((g == 1) ? 2 : 4);
    scan_seq_if bi ();
    assign bi.start = start;
    assign bi.stop  = stop;
    assign bi.mask  = mask;
    assign asel[g]  = bi.sel;
    assign avld[g]  = bi.sel_vld;
    assign abusy[g] = bi.busy;
    assign adone[g] = bi.done;
    scan_seq #(.DWELL(DW)) u_dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bi.slave)
    );
  end

  // Model: a scan is a position within the flattened sequence of enabled channels, each repeated dwell times.
  bit         run[3];
  int         pos[3];
  logic [7:0] lm[3];
  logic [2:0] esel[3];
  logic       evld[3];
  logic       ebusy[3];
  logic       edone[3];

  function automatic logic [2:0] nth(logic [7:0] m, int j);
    int c = 0;
    for (int i = 0; i < 8; i++) begin
      if (m[i]) begin
        if (c == j) return 3'(i);
        c++;
      end
    end
    return 3'd0;
  endfunction

  initial begin
    for (int k = 0; k < 3; k++) begin
      run[k] = 0; pos[k] = 0; lm[k] = '0; esel[k] = '0;
      evld[k] = 0; ebusy[k] = 0; edone[k] = 0;
    end
    forever begin
      @(posedge clk);
      for (int k = 0; k < 3; k++) begin
        if (!rst_n) begin
          run[k] = 0; pos[k] = 0; lm[k] = '0; esel[k] = '0;
          evld[k] = 0; ebusy[k] = 0; edone[k] = 0;
        end else begin
          edone[k] = 0;
          if (run[k]) begin
            if (stop) begin
              run[k] = 0; evld[k] = 0; ebusy[k] = 0;
            end else begin
              pos[k]++;
              if (pos[k] == $countones(lm[k]) * dwv[k]) begin
`ifdef SCAN_SEQ_LOOP_EN
                pos[k] = 0;
                edone[k] = 1;
`else
                run[k] = 0; evld[k] = 0; ebusy[k] = 0; edone[k] = 1;
`endif
              end
              if (run[k]) esel[k] = nth(lm[k], pos[k] / dwv[k]);
            end
          end else if (start && !stop) begin
            if (mask != 8'h00) begin
              lm[k] = mask; run[k] = 1; pos[k] = 0;
              evld[k] = 1; ebusy[k] = 1; esel[k] = nth(mask, 0);
            end else begin
              edone[k] = 1;
            end
          end
        end
      end
    end
  end

  task automatic chk(string nm, int k, int act, int exp);
    checks++;
    if (act != exp) begin
      errs++;
      $display("FAIL %s dut%0d (dwell %0d) t=%0t got %0d want %0d", nm, k, dwv[k], $time, act, exp);
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      for (int k = 0; k < 3; k++) begin
        chk("sel",     k, int'(asel[k]),  int'(esel[k]));
        chk("sel_vld", k, int'(avld[k]),  int'(evld[k]));
        chk("busy",    k, int'(abusy[k]), int'(ebusy[k]));
        chk("done",    k, int'(adone[k]), int'(edone[k]));
      end
    end
  end

  task automatic step(int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic pulse_start(logic [7:0] m);
    start = 1'b1;
    mask  = m;
    step(1);
    start = 1'b0;
  endtask

  task automatic idle_all();
    stop = 1'b1;
    step(1);
    stop = 1'b0;
    step(1);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b1; stop = 1'b0; mask = 8'hFF;
    step(3);
    chk("rst_vld", 2, int'(avld[2]), 0);
    chk("rst_sel", 2, int'(asel[2]), 0);
    chk("rst_busy", 0, int'(abusy[0]), 0);
    rst_n = 1'b1; start = 1'b0;
    step(2);
    chk("rst_nostart", 1, int'(abusy[1]), 0);

    // full scan, all channels
    pulse_start(8'hFF);
    chk("full_t1_sel", 1, int'(asel[1]), 0);
    chk("full_t1_vld", 1, int'(avld[1]), 1);
    step(2);
    chk("full_t3_sel", 1, int'(asel[1]), 1);
    chk("full_t3_d1", 0, int'(asel[0]), 2);
    chk("model_t3", 1, int'(esel[1]), 1);
    step(14);
    chk("full_t17_d4", 2, int'(asel[2]), 4);
`ifdef SCAN_SEQ_LOOP_EN
    chk("loop_t17_sel", 1, int'(asel[1]), 0);
    chk("loop_t17_done", 1, int'(adone[1]), 1);
`else
    chk("full_t17_done", 1, int'(adone[1]), 1);
    chk("full_t17_vld", 1, int'(avld[1]), 0);
    chk("full_t17_sel", 1, int'(asel[1]), 7);
`endif
    idle_all();

    // sparse mask with a mid-scan mask change
    pulse_start(8'b1010_0100);
    chk("sparse_t1", 0, int'(asel[0]), 2);
    mask = 8'h01;
    step(1);
    chk("sparse_t2", 0, int'(asel[0]), 5);
    step(1);
    chk("sparse_t3", 0, int'(asel[0]), 7);
    chk("model_sparse", 0, int'(esel[0]), 7);
    step(1);
    chk("sparse_t4_done", 0, int'(adone[0]), 1);
`ifndef SCAN_SEQ_LOOP_EN
    chk("sparse_t4_vld", 0, int'(avld[0]), 0);
`endif
    idle_all();
    step(10);

    // empty mask
    pulse_start(8'h00);
    chk("empty_done", 2, int'(adone[2]), 1);
    chk("empty_vld", 2, int'(avld[2]), 0);
    chk("empty_done_d1", 0, int'(adone[0]), 1);
    step(1);
    chk("empty_done_clr", 2, int'(adone[2]), 0);

    // start while running is ignored
    pulse_start(8'h11);
    step(3);
    start = 1'b1; mask = 8'hFF;
    step(1);
    start = 1'b0;
    chk("restart_ign", 2, int'(asel[2]), 4);
    idle_all();

    // abort in the last dwell cycle of channel 3
    pulse_start(8'hFF);
    step(15);
    chk("abort_pre", 2, int'(asel[2]), 3);
    stop = 1'b1;
    step(1);
    stop = 1'b0;
    chk("abort_vld", 2, int'(avld[2]), 0);
    chk("abort_busy", 2, int'(abusy[2]), 0);
    chk("abort_done", 2, int'(adone[2]), 0);
    step(5);
    chk("abort_stays", 2, int'(avld[2]), 0);

`ifdef SCAN_SEQ_LOOP_EN
    pulse_start(8'b0000_0011);
    chk("loop_a", 0, int'(asel[0]), 0);
    step(1);
    chk("loop_b", 0, int'(asel[0]), 1);
    step(1);
    chk("loop_c", 0, int'(asel[0]), 0);
    chk("loop_c_done", 0, int'(adone[0]), 1);
    idle_all();
`endif

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      rst_n = ($urandom_range(199) != 0);
      start = ($urandom_range(3) == 0);
      stop  = ($urandom_range(29) == 0);
      mask  = ($urandom_range(7) == 0) ? 8'h00 : 8'($urandom);
      step(1);
    end
    rst_n = 1'b1; start = 1'b0; stop = 1'b0;
    step(2);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, errs);
    $finish;
  end

endmodule
